// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage next-PC controller.
package fetch_pkg;

    // Address width the prediction entry is built for; the top-level
    // DATA_WIDTH parameter is expected to match it.
    localparam int XLEN = 32;

    // Major opcodes of the control-flow instructions the front-end tracks.
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // One in-flight prediction: what fetch assumed, and where to go if the
    // instruction turns out not-taken.
    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] fallthru;
    } pred_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_pred_fifo.sv
// In-order FIFO of predictions for control-flow instructions between fetch
// and execute. Full/empty come from comparing wrap-extended pointers.
module pred_fifo
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_flush,
    input  pred_entry_t i_din,
    output pred_entry_t o_head,
    output logic        o_full,
    output logic        o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    pred_entry_t  r_mem [FIFO_DEPTH];

    // Pointer update: reset or flush empties the queue; push/pop advance independently.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone decide
        // which entries are valid, so stale contents are never observed.
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule : pred_fifo

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage next-PC controller: owns PC_f, tracks predictions of in-flight
// control-flow instructions, checks them at execute and redirects on mispredict.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_f,
    input  logic                  ctrl_f,
    input  logic                  predict_taken_f,
    input  logic [DATA_WIDTH-1:0] branch_target_f,
    input  logic                  resolve_valid_e,
    input  logic                  actual_taken_e,
    input  logic [DATA_WIDTH-1:0] actual_target_e,
    output logic [DATA_WIDTH-1:0] PC_f,
    output logic                  flush_fd,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_flush;
    logic [CNT_WIDTH-1:0]  r_branch_cnt;
    logic [CNT_WIDTH-1:0]  r_mispredict_cnt;
    logic                  r_overflow_err;
    logic                  r_underflow_err;

    pred_entry_t           w_head;
    pred_entry_t           w_new_entry;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_resolve;
    logic                  w_mispredict;
    logic [DATA_WIDTH-1:0] w_recovery;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_overflow;
    logic                  w_underflow;
    logic [DATA_WIDTH-1:0] w_next_pc;

    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);

    // A resolve only counts when there is a prediction to check it against.
    assign w_resolve    = resolve_valid_e && !w_empty;
    assign w_underflow  = resolve_valid_e && w_empty;
    assign w_mispredict = w_resolve &&
                          ((actual_taken_e != w_head.taken) ||
                           (actual_taken_e && (actual_target_e != w_head.target)));
    assign w_recovery   = actual_taken_e ? actual_target_e : w_head.fallthru;

    // The instruction in F is younger than a mispredicting one, so it is
    // squashed rather than tracked. A full queue still accepts a push when
    // the head leaves in the same cycle.
    assign w_push_req = ctrl_f && !stall_f && !w_mispredict;
    assign w_push     = w_push_req && (!w_full || w_resolve);
    assign w_overflow = w_push_req && w_full && !w_resolve;

    assign w_new_entry = '{taken:    predict_taken_f,
                           target:   branch_target_f,
                           fallthru: w_pc_plus4};

    pred_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_pred_fifo (
        .clk     (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_resolve),
        .i_flush (w_mispredict),
        .i_din   (w_new_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-PC select: redirect beats stall, stall beats prediction.
    always_comb begin
        // NOTE: the default assignment up front keeps every path driven, so
        // no latch is inferred when a branch of the if-chain is edited later.
        w_next_pc = w_pc_plus4;
        if (w_mispredict)         w_next_pc = w_recovery;
        else if (stall_f)         w_next_pc = r_pc;
        else if (predict_taken_f) w_next_pc = branch_target_f;
    end

    // PC register and the registered one-cycle flush pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
        end else begin
            r_pc    <= w_next_pc;
            r_flush <= w_mispredict;
        end
    end

    // Performance counters; both wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_resolve)    r_branch_cnt     <= r_branch_cnt + 1'b1;
            if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
        end
    end

    // Sticky protocol-error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (w_overflow)  r_overflow_err  <= 1'b1;
            if (w_underflow) r_underflow_err <= 1'b1;
        end
    end

    assign PC_f           = r_pc;
    assign flush_fd       = r_flush;
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
    assign overflow_err   = r_overflow_err;
    assign underflow_err  = r_underflow_err;

endmodule : fetch_pc_ctrl

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_fetch_pc_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        bit          taken;
        logic [31:0] target;
        logic [31:0] fallthru;
    } model_entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        ctrl_f;
    logic        predict_taken_f;
    logic [31:0] branch_target_f;
    logic        resolve_valid_e;
    logic        actual_taken_e;
    logic [31:0] actual_target_e;
    logic [31:0] PC_f;
    logic        flush_fd;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;
    logic        overflow_err;
    logic        underflow_err;

    // Reference model state.
    model_entry_t m_q[$];
    logic [31:0]  m_pc;
    logic         m_flush;
    logic [31:0]  m_bcnt;
    logic [31:0]  m_mcnt;
    logic         m_ovf;
    logic         m_unf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_f         (stall_f),
        .ctrl_f          (ctrl_f),
        .predict_taken_f (predict_taken_f),
        .branch_target_f (branch_target_f),
        .resolve_valid_e (resolve_valid_e),
        .actual_taken_e  (actual_taken_e),
        .actual_target_e (actual_target_e),
        .PC_f            (PC_f),
        .flush_fd        (flush_fd),
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt),
        .overflow_err    (overflow_err),
        .underflow_err   (underflow_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit          resolve;
        bit          mis;
        bit          push_req;
        int          occ;
        logic [31:0] recov;
        if (rst) begin
            m_q.delete();
            m_pc = 32'h0; m_flush = 0; m_bcnt = 0; m_mcnt = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        occ     = m_q.size();
        resolve = resolve_valid_e && occ > 0;
        mis     = 0;
        recov   = 32'h0;
        if (resolve_valid_e && occ == 0) m_unf = 1;
        if (resolve) begin
            mis = (actual_taken_e != m_q[0].taken) ||
                  (actual_taken_e && actual_target_e != m_q[0].target);
            recov = actual_taken_e ? actual_target_e : m_q[0].fallthru;
            m_bcnt++;
        end
        push_req = ctrl_f && !stall_f && !mis;
        if (mis) begin
            m_q.delete();
            m_mcnt++;
        end else begin
            if (resolve) void'(m_q.pop_front());
            if (push_req) begin
                if (occ == DEPTH && !resolve) m_ovf = 1;
                else m_q.push_back('{predict_taken_f, branch_target_f, m_pc + 32'd4});
            end
        end
        m_flush = mis;
        if (mis)                  m_pc = recov;
        else if (stall_f)         m_pc = m_pc;
        else if (predict_taken_f) m_pc = branch_target_f;
        else                      m_pc = m_pc + 32'd4;
    endtask

    // Apply one cycle of stimulus, clock it, then compare every output.
    task automatic tick(input bit r, input bit st, input bit ct, input bit pt,
                        input logic [31:0] tgt, input bit rv, input bit at,
                        input logic [31:0] atgt);
        rst = r; stall_f = st; ctrl_f = ct; predict_taken_f = pt;
        branch_target_f = tgt; resolve_valid_e = rv; actual_taken_e = at;
        actual_target_e = atgt;
        @(posedge clk);
        model_step();
        #1;
        check("pc",        PC_f,           m_pc);
        check("flush",     flush_fd,       m_flush);
        check("branch",    branch_cnt,     m_bcnt);
        check("mispred",   mispredict_cnt, m_mcnt);
        check("overflow",  overflow_err,   m_ovf);
        check("underflow", underflow_err,  m_unf);
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    // Redirect fetch to an address using a taken prediction without tracking.
    task automatic jump(input logic [31:0] a);
        tick(0, 0, 0, 1, a, 0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] tgt;
        logic [31:0] atgt;
        bit          at;

        // Reset for two cycles, then free-run sequential fetch.
        tick(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        tick(1, 1, 1, 1, 32'h1234, 1, 1, 32'h5678);
        check("reset_pc", PC_f, 32'h0);
        repeat (3) idle();
        check("seq_pc", PC_f, 32'hC);

        // Correctly predicted backward branch at 0x20.
        jump(32'h20);
        tick(0, 0, 1, 1, 32'h10, 0, 0, 32'h0);
        check("bwd_target", PC_f, 32'h10);
        idle();
        tick(0, 0, 0, 0, 32'h0, 1, 1, 32'h10);
        check("bwd_no_flush", flush_fd, 1'b0);
        check("bwd_bcnt", branch_cnt, 32'd1);

        // Wrong direction at 0x40.
        jump(32'h40);
        tick(0, 0, 1, 0, 32'h80, 0, 0, 32'h0);
        tick(0, 0, 0, 0, 32'h0, 1, 1, 32'h80);
        check("wd_pc", PC_f, 32'h80);
        check("wd_flush", flush_fd, 1'b1);
        check("wd_mcnt", mispredict_cnt, 32'd1);
        idle();
        check("wd_flush_drop", flush_fd, 1'b0);

        // JALR at 0x100 predicted not-taken; redirect beats a same-cycle stall+push.
        jump(32'h100);
        tick(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        tick(0, 1, 1, 1, 32'h300, 1, 1, 32'h200);
        check("jalr_pc", PC_f, 32'h200);
        check("jalr_flush", flush_fd, 1'b1);

        // Fill the queue, overflow it, then push+pop while full.
        for (int i = 0; i < DEPTH; i++) tick(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        check("full_no_ovf", overflow_err, 1'b0);
        tick(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        check("ovf_set", overflow_err, 1'b1);
        tick(0, 0, 1, 0, 32'h0, 1, 0, 32'h0);
        for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        check("drain_mcnt", mispredict_cnt, 32'd2);
        check("drain_unf", underflow_err, 1'b0);
        tick(0, 0, 0, 0, 32'h0, 1, 1, 32'h40);
        check("unf_set", underflow_err, 1'b1);

        // PC wrap-around.
        jump(32'hFFFF_FFFC);
        idle();
        check("wrap_pc", PC_f, 32'h0);

        // Reset with three entries pending.
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 1, 32'h500, 0, 0, 32'h0);
        tick(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        check("rst_flush", flush_fd, 1'b0);
        tick(0, 0, 0, 0, 32'h0, 1, 1, 32'h0);
        check("rst_empty", underflow_err, 1'b1);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            tgt  = $urandom() & 32'hFFFF_FFFC;
            at   = 1'($urandom_range(0, 1));
            atgt = ($urandom_range(0, 1) == 1 && m_q.size() > 0) ? m_q[0].target
                                                                 : ($urandom() & 32'hFFFF_FFFC);
            tick($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 tgt,
                 $urandom_range(0, 2) == 0,
                 at, atgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_pc_ctrl
